data_ram: RTL and testbench

//  Parametrised RV32IM data memory, successor to the flat word RAM. It accepts one

---
 rtl/data_ram.sv | 207 ++++++++++++++++++++
 tb/tb_data_ram.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// data_ram: RV32IM data memory with funct3 size decode, byte-lane merge,
// sign/zero-extended loads, error reporting, wait states and clear sweep.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   req_*         valid/ready load/store request (write, funct3, addr, wdata)
//   resp_*        one-cycle response strobe with registered rdata/error
//   init_done     memory usable; stays high until the next reset
module data_ram #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int ADDR_WIDTH     = 12,
  parameter int WAIT_STATES    = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  init_done
);

  localparam int MW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [MW-1:0] LAST = MW'(DEPTH_WORDS - 1);
  localparam logic [3:0] WLOAD =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [MW-1:0] init_cnt;
  logic [3:0]    wait_cnt;
  logic          accept;
  logic          enter_resp;

  logic                  q_write;
  logic [2:0]            q_f3;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic [31:0]           q_wdata;

  // With no wait states the response is produced on the accept edge
  // itself, so the decode looks at the live request while in IDLE.
  logic                  c_write;
  logic [2:0]            c_f3;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [31:0]           c_wdata;

  logic [IW-1:0] c_idx;
  logic [MW-1:0] m_idx;
  logic [1:0]    lane;
  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          legal;
  logic          misal;
  logic          oor;
  logic          err;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wd;
  logic [MW-1:0] mem_wi;

  assign req_ready = (state == S_IDLE) && init_done;
  assign accept    = req_valid && req_ready;

  assign c_write = (state == S_IDLE) ? req_write  : q_write;
  assign c_f3    = (state == S_IDLE) ? req_funct3 : q_f3;
  assign c_addr  = (state == S_IDLE) ? req_addr   : q_addr;
  assign c_wdata = (state == S_IDLE) ? req_wdata  : q_wdata;

  assign c_idx = c_addr[ADDR_WIDTH-1:2];
  assign m_idx = c_idx[MW-1:0];
  assign lane  = c_addr[1:0];

  assign is_b  = (c_f3[1:0] == 2'b00);
  assign is_h  = (c_f3[1:0] == 2'b01);
  assign is_w  = (c_f3 == 3'b010);
  // Unsigned variants (funct3[2]) exist only for loads.
  assign legal = is_w || ((is_b || is_h) && !(c_write && c_f3[2]));
  assign misal = (is_h && lane[0]) || (is_w && (lane != 2'b00));
  assign oor   = 32'(c_idx) >= 32'(DEPTH_WORDS);
  assign err   = !legal || misal || oor;

  assign rd_word = mem[m_idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    st_be   = 4'hF;
    st_data = c_wdata;
    unique case (1'b1)
      is_b: begin
        ld_data = {{24{~c_f3[2] & ld_byte[7]}}, ld_byte};
        st_be   = 4'b0001 << lane;
        st_data = {4{c_wdata[7:0]}};
      end
      is_h: begin
        ld_data = {{16{~c_f3[2] & ld_half[15]}}, ld_half};
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{c_wdata[15:0]}};
      end
      default: begin
        ld_data = rd_word;
        st_be   = 4'hF;
        st_data = c_wdata;
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (init_cnt == LAST) state_nx = S_IDLE;
      S_IDLE:  if (accept)
                 state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt == 4'd0) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign enter_resp = (state_nx == S_RESP);

  always_comb begin
    mem_we = 1'b0;
    mem_be = 4'h0;
    mem_wd = '0;
    mem_wi = '0;
    if (!reset) begin
      if (state == S_INIT) begin
        mem_we = 1'b1;
        mem_be = 4'hF;
        mem_wi = init_cnt;
      end else if (enter_resp && c_write && !err) begin
        mem_we = 1'b1;
        mem_be = st_be;
        mem_wd = st_data;
        mem_wi = m_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_wi][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_write <= req_write;
      q_f3    <= req_funct3;
      q_addr  <= req_addr;
      q_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
      init_cnt   <= '0;
      wait_cnt   <= '0;
      init_done  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_nx;
      resp_valid <= enter_resp;
      if (enter_resp) begin
        resp_error <= err;
        resp_rdata <= (err || c_write) ? 32'd0 : ld_data;
      end
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
      if (state == S_IDLE || (state == S_INIT && init_cnt == LAST))
        init_done <= 1'b1;
      if (accept) wait_cnt <= WLOAD;
      else if (state == S_WAIT) wait_cnt <= wait_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed plus random load/store checks of data_ram against
// a byte-array reference model; instance a: no waits + clear, b: 3 waits.
module tb_data_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [2:0]  req_funct3 [2];
  logic [11:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_error [2];
  logic        init_done  [2];

  data_ram #(
    .DEPTH_WORDS(16), .ADDR_WIDTH(12),
    .WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_funct3(req_funct3[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_error(resp_error[0]), .init_done(init_done[0])
  );

  data_ram #(
    .DEPTH_WORDS(16), .ADDR_WIDTH(12),
    .WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_funct3(req_funct3[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_error(resp_error[1]), .init_done(init_done[1])
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mb [2][64];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int waits(input int s);
    return (s == 1) ? 3 : 0;
  endfunction

  function automatic void model(
    input int s, input logic wr, input logic [2:0] f3,
    input logic [11:0] a, input logic [31:0] wd,
    output logic [31:0] rd, output logic er);
    int n;
    int ai;
    logic [31:0] v;
    case (f3)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd4: n = wr ? 0 : 1;
      3'd5: n = wr ? 0 : 2;
      default: n = 0;
    endcase
    ai = int'(a);
    rd = '0;
    er = 1'b0;
    if (n == 0) er = 1'b1;
    else if (ai % n != 0) er = 1'b1;
    else if (ai / 4 >= 16) er = 1'b1;
    else if (wr) begin
      for (int i = 0; i < n; i++) mb[s][ai+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++)
        v = v | (32'(mb[s][ai+i]) << (8*i));
      if (f3 < 3'd4 && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endfunction

  task automatic op(input int s, input logic wr, input logic [2:0] f3,
                    input logic [11:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output logic er);
    logic [31:0] mrd;
    logic mer;
    int k;
    int lat;
    rd = '0;
    er = 1'b0;
    @(negedge clk);
    req_write[s]  = wr;
    req_funct3[s] = f3;
    req_addr[s]   = a;
    req_wdata[s]  = wd;
    req_valid[s]  = 1'b1;
    k = 0;
    while (!req_ready[s] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready[s]) begin
      chk("ready_timeout", 32'(req_ready[s]), 32'd1);
      req_valid[s] = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      req_valid[s] = 1'b0;
      lat = 1;
      while (!resp_valid[s] && lat < 30) begin
        chk("busy_ready", 32'(req_ready[s]), 32'd0);
        @(negedge clk);
        lat++;
      end
      chk("latency", 32'(lat), 32'(waits(s) + 1));
      chk("resp_ready", 32'(req_ready[s]), 32'd0);
      rd = resp_rdata[s];
      er = resp_error[s];
      model(s, wr, f3, a, wd, mrd, mer);
      chk("rdata", rd, mrd);
      chk("error", 32'(er), 32'(mer));
      @(negedge clk);
      chk("strobe", 32'(resp_valid[s]), 32'd0);
      chk("hold", resp_rdata[s], rd);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic early;
    int k;
    logic [10:0] rp;
    logic [10:0] rr;
    logic [31:0] t5_rd;
    logic saw;
    logic rw;
    logic [2:0] rf;
    logic [11:0] ra;

    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b1;
      req_valid[s] = 1'b0;
      req_write[s] = 1'b0;
      req_funct3[s] = 3'd0;
      req_addr[s] = '0;
      req_wdata[s] = '0;
      for (int i = 0; i < 64; i++) mb[s][i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(req_ready[s]), 32'd0);
      chk("rst_rvalid", 32'(resp_valid[s]), 32'd0);
      chk("rst_rdata", resp_rdata[s], 32'd0);
      chk("rst_err", 32'(resp_error[s]), 32'd0);
      chk("rst_done", 32'(init_done[s]), 32'd0);
    end

    // T1: clear sweep takes one cycle per word
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    chk("b_init_done", 32'(init_done[1]), 32'd1);
    k = 1;
    early = 1'b0;
    while (!init_done[0] && k < 40) begin
      if (req_ready[0]) early = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("a_init_cycles", 32'(k), 32'd16);
    chk("a_ready_early", 32'(early), 32'd0);
    chk("a_ready_done", 32'(req_ready[0]), 32'd1);
    op(0, 1'b0, 3'b010, 12'h03C, 32'd0, rd, er);
    chk("t1_rd", rd, 32'd0);
    chk("t1_er", 32'(er), 32'd0);

    // T2
    op(0, 1'b1, 3'b010, 12'h010, 32'h1234_5678, rd, er);
    op(0, 1'b0, 3'b000, 12'h013, 32'd0, rd, er);
    chk("t2_lb", rd, 32'h0000_0012);
    op(0, 1'b0, 3'b001, 12'h012, 32'd0, rd, er);
    chk("t2_lh", rd, 32'h0000_1234);
    op(0, 1'b0, 3'b100, 12'h010, 32'd0, rd, er);
    chk("t2_lbu", rd, 32'h0000_0078);

    // T3
    op(0, 1'b1, 3'b000, 12'h011, 32'h0000_0080, rd, er);
    op(0, 1'b0, 3'b010, 12'h010, 32'd0, rd, er);
    chk("t3_lw", rd, 32'h1234_8078);
    op(0, 1'b0, 3'b000, 12'h011, 32'd0, rd, er);
    chk("t3_lb", rd, 32'hFFFF_FF80);
    op(0, 1'b0, 3'b100, 12'h011, 32'd0, rd, er);
    chk("t3_lbu", rd, 32'h0000_0080);
    op(0, 1'b1, 3'b001, 12'h012, 32'h0000_BEEF, rd, er);
    op(0, 1'b0, 3'b010, 12'h010, 32'd0, rd, er);
    chk("t3_lw2", rd, 32'hBEEF_8078);

    // T4: errors
    op(0, 1'b0, 3'b010, 12'h002, 32'd0, rd, er);
    chk("t4_lw_er", 32'(er), 32'd1);
    chk("t4_lw_rd", rd, 32'd0);
    op(0, 1'b1, 3'b001, 12'h001, 32'hFFFF_FFFF, rd, er);
    chk("t4_sh_er", 32'(er), 32'd1);
    op(0, 1'b0, 3'b011, 12'h010, 32'd0, rd, er);
    chk("t4_f3_er", 32'(er), 32'd1);
    chk("t4_f3_rd", rd, 32'd0);
    op(0, 1'b1, 3'b000, 12'h040, 32'h0000_0055, rd, er);
    chk("t4_oor_er", 32'(er), 32'd1);
    op(0, 1'b1, 3'b101, 12'h014, 32'h0000_0055, rd, er);
    chk("t4_shu_er", 32'(er), 32'd1);
    op(0, 1'b0, 3'b010, 12'h010, 32'd0, rd, er);
    chk("t4_keep", rd, 32'hBEEF_8078);
    op(0, 1'b0, 3'b010, 12'h000, 32'd0, rd, er);
    chk("t4_keep0", rd, 32'd0);

    // random traffic on instance a
    repeat (80) begin
      rw = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      ra = 12'($urandom_range(0, 79));
      op(0, rw, rf, ra, $urandom, rd, er);
    end

    // instance b: fill every word so later loads are defined
    for (int w = 0; w < 16; w++)
      op(1, 1'b1, 3'b010, 12'(4*w), $urandom, rd, er);
    op(1, 1'b1, 3'b010, 12'h020, 32'h1122_3344, rd, er);

    // T5: back-to-back with valid held high
    @(negedge clk);
    req_write[1]  = 1'b0;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 12'h020;
    req_valid[1]  = 1'b1;
    chk("t5_ready0", 32'(req_ready[1]), 32'd1);
    rp = '0;
    rr = '0;
    t5_rd = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      rp[i] = resp_valid[1];
      rr[i] = req_ready[1];
      if (i == 9) t5_rd = resp_rdata[1];
      if (i == 10) req_valid[1] = 1'b0;
    end
    chk("t5_resp_pat", 32'(rp), 32'h210);
    chk("t5_ready_pat", 32'(rr), 32'h420);
    chk("t5_rdata", t5_rd, 32'h1122_3344);

    // T6: reset while the store waits
    @(negedge clk);
    req_write[1]  = 1'b1;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 12'h020;
    req_wdata[1]  = 32'hAAAA_AAAA;
    req_valid[1]  = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset[1] = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid[1]) saw = 1'b1;
      if (i == 1) chk("t6_done_low", 32'(init_done[1]), 32'd0);
      if (i == 2) reset[1] = 1'b0;
    end
    chk("t6_no_resp", 32'(saw), 32'd0);
    chk("t6_done", 32'(init_done[1]), 32'd1);
    op(1, 1'b0, 3'b010, 12'h020, 32'd0, rd, er);
    chk("t6_intact", rd, 32'h1122_3344);

    // random traffic on instance b
    repeat (20) begin
      rw = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      ra = 12'($urandom_range(0, 79));
      op(1, rw, rf, ra, $urandom, rd, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
